// File: rtl/mdu_pkg.sv
// ============================================================================
// Module     : mdu_pkg
// Description: Shared constants and FSM encoding for the RV32M mul/div unit.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

package mdu_pkg;

    localparam int MDU_XLEN    = 32;
    localparam int MDU_LATENCY = MDU_XLEN + 2;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        CALC = 2'd2,
        FIN  = 2'd3
    } mdu_state_e;

    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_operand_prep.sv
// ============================================================================
// Module     : mdu_operand_prep
// Description: Operand magnitudes and result/remainder signs from funct3.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_operand_prep
    import mdu_pkg::*;
#(
    parameter int XLEN = MDU_XLEN
) (
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    output logic [XLEN-1:0] o_abs_a,
    output logic [XLEN-1:0] o_abs_b,
    output logic            o_neg_q,
    output logic            o_neg_r
);

    logic w_signed_a;
    logic w_signed_b;
    logic w_neg_a;
    logic w_neg_b;

    always_comb begin
        w_signed_a = 1'b0;
        w_signed_b = 1'b0;
        case (i_funct3)
            F3_MUL, F3_MULH, F3_DIV, F3_REM: begin
                w_signed_a = 1'b1;
                w_signed_b = 1'b1;
            end
            F3_MULHSU: w_signed_a = 1'b1;
            default:   ;
        endcase
        w_neg_a = w_signed_a & i_op_a[XLEN-1];
        w_neg_b = w_signed_b & i_op_b[XLEN-1];
        o_abs_a = w_neg_a ? -i_op_a : i_op_a;
        o_abs_b = w_neg_b ? -i_op_b : i_op_b;
        o_neg_q = w_neg_a ^ w_neg_b;
        // Remainder follows the dividend's sign.
        o_neg_r = w_neg_a;
    end

endmodule

`default_nettype wire

// File: rtl/mul_div_unit.sv
// ============================================================================
// Module     : mul_div_unit
// Description: Iterative RV32M multiply/divide, fixed XLEN+2 cycle latency.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int XLEN = MDU_XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam int CW = $clog2(XLEN) + 1;

    mdu_state_e        r_state_q, w_state_d;
    logic [2:0]        r_f3_q, w_f3_d;
    logic [XLEN-1:0]   r_a_q, w_a_d;
    logic [XLEN-1:0]   r_b_q, w_b_d;
    logic [XLEN-1:0]   r_bmag_q, w_bmag_d;
    logic              r_negq_q, w_negq_d;
    logic              r_negr_q, w_negr_d;
    logic [2*XLEN-1:0] r_acc_q, w_acc_d;
    logic [CW-1:0]     r_cnt_q, w_cnt_d;
    logic              r_busy_q, w_busy_d;
    logic              r_done_q, w_done_d;
    logic [XLEN-1:0]   r_result_q, w_result_d;
    logic [4:0]        r_rd_q, w_rd_d;

    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic              w_neg_q;
    logic              w_neg_r;
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_step;
    logic [XLEN+1:0]   w_div_diff;
    logic [2*XLEN-1:0] w_div_step;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;
    logic              w_bzero;
    logic [XLEN-1:0]   w_fin;

    mdu_operand_prep #(.XLEN(XLEN)) u_prep (
        .i_funct3 (r_f3_q),
        .i_op_a   (r_a_q),
        .i_op_b   (r_b_q),
        .o_abs_a  (w_abs_a),
        .o_abs_b  (w_abs_b),
        .o_neg_q  (w_neg_q),
        .o_neg_r  (w_neg_r)
    );

    // Accumulator is {hi, lo}: product halves, or {remainder, dividend/quotient}.
    always_comb begin
        w_mul_sum  = {1'b0, r_acc_q[2*XLEN-1:XLEN]}
                   + {1'b0, (r_acc_q[0] ? r_bmag_q : {XLEN{1'b0}})};
        w_mul_step = {w_mul_sum, r_acc_q[XLEN-1:1]};
        w_div_diff = {1'b0, r_acc_q[2*XLEN-1:XLEN-1]} - {2'b00, r_bmag_q};
        w_div_step = w_div_diff[XLEN+1]
                   ? {r_acc_q[2*XLEN-2:XLEN-1], r_acc_q[XLEN-2:0], 1'b0}
                   : {w_div_diff[XLEN-1:0],     r_acc_q[XLEN-2:0], 1'b1};

        w_prod  = r_negq_q ? -r_acc_q : r_acc_q;
        w_quot  = r_negq_q ? -r_acc_q[XLEN-1:0] : r_acc_q[XLEN-1:0];
        w_rem   = r_negr_q ? -r_acc_q[2*XLEN-1:XLEN] : r_acc_q[2*XLEN-1:XLEN];
        w_bzero = (r_bmag_q == {XLEN{1'b0}});
        case (r_f3_q)
            F3_MUL:          w_fin = w_prod[XLEN-1:0];
            F3_DIV, F3_DIVU: w_fin = w_bzero ? {XLEN{1'b1}} : w_quot;
            F3_REM, F3_REMU: w_fin = w_bzero ? r_a_q : w_rem;
            default:         w_fin = w_prod[2*XLEN-1:XLEN];
        endcase
    end

    always_comb begin
        w_state_d  = r_state_q;
        w_f3_d     = r_f3_q;
        w_a_d      = r_a_q;
        w_b_d      = r_b_q;
        w_bmag_d   = r_bmag_q;
        w_negq_d   = r_negq_q;
        w_negr_d   = r_negr_q;
        w_acc_d    = r_acc_q;
        w_cnt_d    = r_cnt_q;
        w_busy_d   = r_busy_q;
        w_done_d   = 1'b0;
        w_result_d = r_result_q;
        w_rd_d     = r_rd_q;
        case (r_state_q)
            IDLE: begin
                if (start) begin
                    w_f3_d    = funct3;
                    w_a_d     = op_a;
                    w_b_d     = op_b;
                    w_rd_d    = rd_in;
                    w_busy_d  = 1'b1;
                    w_state_d = PREP;
                end
            end
            PREP: begin
                w_acc_d   = {{XLEN{1'b0}}, w_abs_a};
                w_bmag_d  = w_abs_b;
                w_negq_d  = w_neg_q;
                w_negr_d  = w_neg_r;
                w_cnt_d   = '0;
                w_state_d = CALC;
            end
            CALC: begin
                w_acc_d = is_div(r_f3_q) ? w_div_step : w_mul_step;
                w_cnt_d = r_cnt_q + 1'b1;
                if (r_cnt_q == CW'(XLEN - 1)) begin
                    w_state_d = FIN;
                end
            end
            FIN: begin
                w_result_d = w_fin;
                w_done_d   = 1'b1;
                w_busy_d   = 1'b0;
                w_state_d  = IDLE;
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q  <= IDLE;
            r_f3_q     <= '0;
            r_a_q      <= '0;
            r_b_q      <= '0;
            r_bmag_q   <= '0;
            r_negq_q   <= 1'b0;
            r_negr_q   <= 1'b0;
            r_acc_q    <= '0;
            r_cnt_q    <= '0;
            r_busy_q   <= 1'b0;
            r_done_q   <= 1'b0;
            r_result_q <= '0;
            r_rd_q     <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_f3_q     <= w_f3_d;
            r_a_q      <= w_a_d;
            r_b_q      <= w_b_d;
            r_bmag_q   <= w_bmag_d;
            r_negq_q   <= w_negq_d;
            r_negr_q   <= w_negr_d;
            r_acc_q    <= w_acc_d;
            r_cnt_q    <= w_cnt_d;
            r_busy_q   <= w_busy_d;
            r_done_q   <= w_done_d;
            r_result_q <= w_result_d;
            r_rd_q     <= w_rd_d;
        end
    end

    assign busy   = r_busy_q;
    assign done   = r_done_q;
    assign result = r_result_q;
    assign rd_out = r_rd_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// ============================================================================
// Module     : tb_mul_div_unit
// Description: Self-checking bench for mul_div_unit against an arithmetic model.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int n_checks = 0;
    int n_errors = 0;

    mul_div_unit #(.XLEN(32)) u_dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .rd_in  (rd_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rd_out (rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // RV32M semantics from plain 64-bit arithmetic (mod 2^64).
    function automatic logic [31:0] ref_mdu(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        logic [31:0] r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        r  = '0;
        case (f3)
            3'd0: begin p = ua * ub; r = p[31:0];  end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: begin
                if (b == 0)                                  r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == '1)      r = a;
                else                                         r = $signed(a) / $signed(b);
            end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0)                                  r = a;
                else if (a == 32'h8000_0000 && b == '1)      r = 32'h0;
                else                                         r = $signed(a) % $signed(b);
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Issue one op and follow it to done; poke_at >= 0 injects a stray start while busy.
    task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp, input int poke_at);
        int lat;
        int busy_cnt;
        @(negedge clk);
        start = 1'b1; funct3 = f3; op_a = a; op_b = b; rd_in = rd;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        busy_cnt = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cnt++;
            if (lat == poke_at) begin
                start = 1'b1; funct3 = 3'd0; op_a = 32'h1234_5678; op_b = 32'h9; rd_in = 5'd17;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        chk({tag, "_latency"}, lat, 34);
        chk({tag, "_busycyc"}, busy_cnt, 34);
        chk({tag, "_busy_at_done"}, {31'b0, busy}, 32'd0);
        chk({tag, "_result"}, result, exp);
        chk({tag, "_rd"}, {27'b0, rd_out}, {27'b0, rd});
    endtask

    initial begin
        int lat;
        int dones;
        logic [2:0]  rf3;
        logic [31:0] ra, rb;
        logic [4:0]  rrd;

        reset = 1'b1; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",   {31'b0, busy}, 32'd0);
        chk("rst_done",   {31'b0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_rd",     {27'b0, rd_out}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        do_op("mul",    3'd0, 32'd7,        32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, -1);
        do_op("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000, -1);
        do_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, -1);
        do_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF, -1);
        do_op("div",    3'd4, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFD, -1);
        do_op("rem",    3'd6, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFF, -1);
        do_op("divu",   3'd5, 32'd7, 32'd2, 5'd8, 32'd3, -1);
        do_op("remu",   3'd7, 32'd7, 32'd2, 5'd9, 32'd1, -1);
        do_op("div0",   3'd4, 32'd5, 32'd0, 5'd10, 32'hFFFF_FFFF, -1);
        do_op("remu0",  3'd7, 32'd5, 32'd0, 5'd11, 32'd5, -1);
        do_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, -1);
        do_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0, -1);
        do_op("ignore", 3'd5, 32'd100, 32'd7, 5'd5, 32'd14, 10);

        // Reset 20 cycles into an op aborts it silently.
        @(negedge clk);
        start = 1'b1; funct3 = 3'd5; op_a = 32'd1000; op_b = 32'd3; rd_in = 5'd20;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy",   {31'b0, busy}, 32'd0);
        chk("abort_done",   {31'b0, done}, 32'd0);
        chk("abort_result", result, 32'd0);
        chk("abort_rd",     {27'b0, rd_out}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        chk("abort_no_done", dones, 0);

        // start held across done: the second op is taken in the done cycle.
        @(negedge clk);
        start = 1'b1; funct3 = 3'd0; op_a = 32'd6; op_b = 32'd7; rd_in = 5'd21;
        @(posedge clk); #1;
        funct3 = 3'd5; op_a = 32'd90; op_b = 32'd4; rd_in = 5'd22;
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("b2b_first_lat", lat, 34);
        chk("b2b_first_res", result, 32'd42);
        chk("b2b_first_rd",  {27'b0, rd_out}, 32'd21);
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_accept_busy", {31'b0, busy}, 32'd1);
        chk("b2b_accept_done", {31'b0, done}, 32'd0);
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("b2b_second_lat", lat, 34);
        chk("b2b_second_res", result, 32'd22);
        chk("b2b_second_rd",  {27'b0, rd_out}, 32'd22);

        for (int i = 0; i < 1000; i++) begin
            rf3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0: ra = 32'h0;
                1: ra = 32'h8000_0000;
                2: ra = 32'hFFFF_FFFF;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0: rb = 32'h0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'h1;
                3: rb = 32'($urandom_range(1, 255));
                default: rb = $urandom;
            endcase
            rrd = 5'($urandom);
            do_op("rand", rf3, ra, rb, rrd, ref_mdu(rf3, ra, rb), -1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
